// File: rtl/asrv32_regfile_sb.sv
// ASRV32 integer register file with per-register busy scoreboard.
// Two registered read ports (optional write-to-read bypass), one write port,
// and a scoreboard that flags destinations of in-flight long-latency ops.
module asrv32_regfile_sb #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,  // 16 (RV32E) or 32 (RV32I)
  parameter int BYPASS    = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce_rd,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic            o_illegal_addr,
  input  logic            i_ce_wr,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  input  logic            i_mark_en,
  input  logic [4:0]      i_mark_addr,
  input  logic            i_flush
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            busy;
  } rd_port_t;

  // x0 has no storage: it is hard-wired to zero and never busy.
  logic [XLEN-1:0]      regs [1:REG_COUNT-1];
  logic [REG_COUNT-1:1] busy;

  logic     wr_ok;
  logic     mark_ok;
  rd_port_t rs1_next;
  rd_port_t rs2_next;
  logic     illegal_next;

  function automatic logic addr_legal(input logic [4:0] a);
    return 32'(a) < REG_COUNT;
  endfunction

  // Looks up one read port, applying the same-cycle write bypass when enabled.
  // Address 0 and out-of-range addresses match no storage slot and read as 0.
  function automatic rd_port_t read_port(input logic [4:0] a);
    rd_port_t p;
    p = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (a == 5'(r)) begin
        p.data = regs[r];
        p.busy = busy[r];
      end
    end
    if (BYPASS != 0 && wr_ok && a == i_rd_addr) begin
      p.data = i_rd_data;
      p.busy = 1'b0;
    end
    return p;
  endfunction

  // Qualify write and mark requests: x0 and out-of-range targets are dropped.
  assign wr_ok   = i_ce_wr   && (i_rd_addr   != 5'd0) && addr_legal(i_rd_addr);
  assign mark_ok = i_mark_en && (i_mark_addr != 5'd0) && addr_legal(i_mark_addr);

  // Next values for the registered read outputs.
  // NOTE: every combinational output gets a value on every path (defaults set
  // first inside read_port), so no latch can be inferred.
  always_comb begin
    rs1_next     = read_port(i_rs1_addr);
    rs2_next     = read_port(i_rs2_addr);
    illegal_next = !addr_legal(i_rs1_addr) || !addr_legal(i_rs2_addr);
  end

  // Register array and scoreboard update; flush beats mark beats write-clear.
  // NOTE: the array is reset because architectural state must read 0 after
  // reset; this costs a reset net on every bit but is required here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 1; r < REG_COUNT; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (wr_ok && i_rd_addr == 5'(r)) regs[r] <= i_rd_data;
        if (i_flush)                              busy[r] <= 1'b0;
        else if (mark_ok && i_mark_addr == 5'(r)) busy[r] <= 1'b1;
        else if (wr_ok && i_rd_addr == 5'(r))     busy[r] <= 1'b0;
      end
    end
  end

  // Capture read results on i_ce_rd; hold otherwise.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rs1_data     <= '0;
      o_rs2_data     <= '0;
      o_rs1_busy     <= 1'b0;
      o_rs2_busy     <= 1'b0;
      o_illegal_addr <= 1'b0;
    end else if (i_ce_rd) begin
      o_rs1_data     <= rs1_next.data;
      o_rs2_data     <= rs2_next.data;
      o_rs1_busy     <= rs1_next.busy;
      o_rs2_busy     <= rs2_next.busy;
      o_illegal_addr <= illegal_next;
    end
  end

endmodule

// File: tb/tb_asrv32_regfile_sb.sv
// Self-checking bench: drives two register files in lockstep
// (RV32I with bypass, RV32E without bypass) from one vector table.
module tb_asrv32_regfile_sb;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic        ce_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ce_wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        mark;
    logic [4:0]  ma;
    logic        flush;
    exp_t        ea;
    exp_t        eb;
  } vec_t;

  typedef struct {
    string name;
    exp_t  ea;
    exp_t  eb;
  } sb_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ce_rd, i_ce_wr, i_mark_en, i_flush;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, i_mark_addr;
  logic [31:0] i_rd_data;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_b1, a_b2, a_ill, b_b1, b_b2, b_ill;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  sb_t  sb[$];

  always #5 i_clk = ~i_clk;

  asrv32_regfile_sb #(.XLEN(32), .REG_COUNT(32), .BYPASS(1)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce_rd(i_ce_rd),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_data(a_d1), .o_rs2_data(a_d2), .o_rs1_busy(a_b1), .o_rs2_busy(a_b2),
    .o_illegal_addr(a_ill), .i_ce_wr(i_ce_wr), .i_rd_addr(i_rd_addr),
    .i_rd_data(i_rd_data), .i_mark_en(i_mark_en), .i_mark_addr(i_mark_addr),
    .i_flush(i_flush)
  );

  asrv32_regfile_sb #(.XLEN(32), .REG_COUNT(16), .BYPASS(0)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce_rd(i_ce_rd),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_data(b_d1), .o_rs2_data(b_d2), .o_rs1_busy(b_b1), .o_rs2_busy(b_b2),
    .o_illegal_addr(b_ill), .i_ce_wr(i_ce_wr), .i_rd_addr(i_rd_addr),
    .i_rd_data(i_rd_data), .i_mark_en(i_mark_en), .i_mark_addr(i_mark_addr),
    .i_flush(i_flush)
  );

  function automatic exp_t e(input logic [31:0] d1, input logic [31:0] d2,
                             input logic b1, input logic b2, input logic ill);
    exp_t x;
    x.d1 = d1; x.d2 = d2; x.b1 = b1; x.b2 = b2; x.ill = ill;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_port(input string name, input exp_t act, input exp_t expv);
    check({name, ".rs1_data"}, act.d1, expv.d1);
    check({name, ".rs2_data"}, act.d2, expv.d2);
    check({name, ".rs1_busy"}, 32'(act.b1), 32'(expv.b1));
    check({name, ".rs2_busy"}, 32'(act.b2), 32'(expv.b2));
    check({name, ".illegal"},  32'(act.ill), 32'(expv.ill));
  endtask

  task automatic check_both(input string name, input exp_t ea, input exp_t eb);
    check_port({name, "/A"}, e(a_d1, a_d2, a_b1, a_b2, a_ill), ea);
    check_port({name, "/B"}, e(b_d1, b_d2, b_b1, b_b2, b_ill), eb);
  endtask

  task automatic add(input string n, input logic ce_rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic ce_wr, input logic [4:0] rd,
                     input logic [31:0] wd, input logic mark, input logic [4:0] ma,
                     input logic flush, input exp_t ea, input exp_t eb);
    vec_t v;
    v.name = n; v.ce_rd = ce_rd; v.rs1 = rs1; v.rs2 = rs2; v.ce_wr = ce_wr;
    v.rd = rd; v.wd = wd; v.mark = mark; v.ma = ma; v.flush = flush;
    v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    i_ce_rd = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_ce_wr = 0; i_rd_addr = 0;
    i_rd_data = 0; i_mark_en = 0; i_mark_addr = 0; i_flush = 0;
  endtask

  // Pop the oldest expectation and compare it against both DUTs.
  task automatic pop_and_check();
    sb_t s;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end else begin
      n_checks--;
      s = sb.pop_front();
      check_both(s.name, s.ea, s.eb);
    end
  endtask

  initial begin
    exp_t z;
    sb_t  s;
    z = e(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // name          rd rs1 rs2 wr rd  wdata          mk ma  fl  A-expected                            B-expected
    add("rst_read",  1, 5,  0,  0, 0,  32'h0,         0, 0,  0, z,                                   z);
    add("wr7_byp",   1, 7,  7,  1, 7,  32'hDEADBEEF,  0, 0,  0, e(32'hDEADBEEF,32'hDEADBEEF,0,0,0),  z);
    add("rd7",       1, 7,  0,  0, 0,  32'h0,         0, 0,  0, e(32'hDEADBEEF,0,0,0,0),             e(32'hDEADBEEF,0,0,0,0));
    add("mark3",     0, 0,  0,  0, 0,  32'h0,         1, 3,  0, e(32'hDEADBEEF,0,0,0,0),             e(32'hDEADBEEF,0,0,0,0));
    add("rd3_busy",  1, 0,  3,  0, 0,  32'h0,         0, 0,  0, e(0,0,0,1,0),                        e(0,0,0,1,0));
    add("wr3_byp",   1, 3,  3,  1, 3,  32'h55,        0, 0,  0, e(32'h55,32'h55,0,0,0),              e(0,0,1,1,0));
    add("mark_wr3",  1, 3,  0,  1, 3,  32'h66,        1, 3,  0, e(32'h66,0,0,0,0),                   e(32'h55,0,0,0,0));
    add("rd3_mark",  1, 3,  3,  0, 0,  32'h0,         0, 0,  0, e(32'h66,32'h66,1,1,0),              e(32'h66,32'h66,1,1,0));
    add("x0_wr_mk",  1, 0,  0,  1, 0,  32'hFFFFFFFF,  1, 0,  0, z,                                   z);
    add("x0_rd",     1, 0,  0,  0, 0,  32'h0,         0, 0,  0, z,                                   z);
    add("wr20_mk",   0, 0,  0,  1, 20, 32'h1234,      1, 20, 0, z,                                   z);
    add("rd20",      1, 20, 20, 0, 0,  32'h0,         0, 0,  0, e(32'h1234,32'h1234,1,1,0),          e(0,0,0,0,1));
    add("hold_wr20", 0, 0,  0,  1, 20, 32'h9999,      0, 0,  0, e(32'h1234,32'h1234,1,1,0),          e(0,0,0,0,1));
    add("rd20_new",  1, 20, 0,  0, 0,  32'h0,         0, 0,  0, e(32'h9999,0,0,0,0),                 e(0,0,0,0,1));
    add("rd15_1",    1, 15, 1,  0, 0,  32'h0,         0, 0,  0, z,                                   z);
    add("mark4",     0, 0,  0,  0, 0,  32'h0,         1, 4,  0, z,                                   z);
    add("mark9",     0, 0,  0,  0, 0,  32'h0,         1, 9,  0, z,                                   z);
    add("rd4_9",     1, 4,  9,  0, 0,  32'h0,         0, 0,  0, e(0,0,1,1,0),                        e(0,0,1,1,0));
    add("remark4",   0, 0,  0,  0, 0,  32'h0,         1, 4,  0, e(0,0,1,1,0),                        e(0,0,1,1,0));
    add("flush_mk6", 0, 0,  0,  0, 0,  32'h0,         1, 6,  1, e(0,0,1,1,0),                        e(0,0,1,1,0));
    add("rd4_9_fl",  1, 4,  9,  0, 0,  32'h0,         0, 0,  0, z,                                   z);
    add("rd6_6_fl",  1, 6,  6,  0, 0,  32'h0,         0, 0,  0, z,                                   z);

    // Reset state, checked while reset is still asserted.
    idle_inputs();
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check_both("in_reset", z, z);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Table: drive at the falling edge, push expectation, compare after the rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      i_ce_rd = vecs[i].ce_rd; i_rs1_addr = vecs[i].rs1; i_rs2_addr = vecs[i].rs2;
      i_ce_wr = vecs[i].ce_wr; i_rd_addr = vecs[i].rd; i_rd_data = vecs[i].wd;
      i_mark_en = vecs[i].mark; i_mark_addr = vecs[i].ma; i_flush = vecs[i].flush;
      s.name = vecs[i].name; s.ea = vecs[i].ea; s.eb = vecs[i].eb;
      sb.push_back(s);
      @(posedge i_clk);
      #1;
      pop_and_check();
      @(negedge i_clk);
    end

    // Make outputs non-zero, then assert reset asynchronously mid-write of x2.
    idle_inputs();
    i_ce_rd = 1; i_rs1_addr = 7;
    @(posedge i_clk);
    #1;
    check("pre_rst.A.rs1_data", a_d1, 32'hDEADBEEF);
    @(negedge i_clk);
    i_ce_rd = 1; i_rs1_addr = 2; i_rs2_addr = 7;
    i_ce_wr = 1; i_rd_addr = 2; i_rd_data = 32'hAA;
    #2;
    i_rst_n = 1'b0;
    #1;
    check_both("async_rst", z, z);
    @(posedge i_clk);
    #1;
    check_both("rst_hold", z, z);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_inputs();
    i_ce_rd = 1; i_rs1_addr = 2; i_rs2_addr = 7;
    s.name = "post_rst_x2_x7"; s.ea = z; s.eb = z;
    sb.push_back(s);
    @(posedge i_clk);
    #1;
    pop_and_check();
    @(negedge i_clk);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
